// File: rtl/fft_stage_unshuffle.sv
// Reorders one frame from butterfly-pair order (for a given stage) back to natural index order.
// Single frame buffer: the whole frame is filled, then drained; fill and drain never overlap.
module fft_stage_unshuffle #(
    parameter int  SAMPLES = 8,
    parameter int  WIDTH   = 3,
    localparam int LOG2    = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LOG2-1:0]  stage,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LOG2-1:0]  out_index,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [LOG2-1:0] MAX_STAGE = LOG2'(LOG2 - 1);
    localparam logic [LOG2-1:0] LAST_IDX  = LOG2'(SAMPLES - 1);

    state_t           state, state_nxt;
    logic [LOG2-1:0]  wr_cnt, wr_cnt_nxt;
    logic [LOG2-1:0]  rd_cnt, rd_cnt_nxt;
    logic [LOG2-1:0]  stage_q, stage_nxt;
    logic [LOG2-1:0]  stage_clamped, stage_use, wr_addr;
    logic             wr_en;
    logic [WIDTH-1:0] mem [SAMPLES];

    // Natural index of the k-th word of a stage-s butterfly-ordered stream.
    function automatic logic [LOG2-1:0] map_index(input logic [LOG2-1:0] s,
                                                   input logic [LOG2-1:0] k);
        int p;
        int j;
        int base;
        int idx;
        p    = int'(k) >> 1;
        j    = p & ((1 << s) - 1);
        base = (p >> s) << (s + 1);
        idx  = base + j + (k[0] ? (1 << s) : 0);
        return idx[LOG2-1:0];
    endfunction

    // The stage used for word 0 comes straight from the port; later words reuse the latched copy.
    always_comb begin
        stage_clamped = (stage > MAX_STAGE) ? MAX_STAGE : stage;
        stage_use     = (wr_cnt == '0) ? stage_clamped : stage_q;
        wr_addr       = map_index(stage_use, wr_cnt);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        stage_nxt  = stage_q;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_index  = '0;
        out_last   = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en     = 1'b1;
                    stage_nxt = stage_use;
                    if (wr_cnt == LAST_IDX) begin
                        wr_cnt_nxt = '0;
                        state_nxt  = DRAIN;
                    end else begin
                        wr_cnt_nxt = wr_cnt + LOG2'(1);
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = mem[rd_cnt];
                out_index = rd_cnt;
                out_last  = (rd_cnt == LAST_IDX);
                if (out_ready) begin
                    if (rd_cnt == LAST_IDX) begin
                        rd_cnt_nxt = '0;
                        state_nxt  = FILL;
                    end else begin
                        rd_cnt_nxt = rd_cnt + LOG2'(1);
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            stage_q <= '0;
        end else begin
            state   <= state_nxt;
            wr_cnt  <= wr_cnt_nxt;
            rd_cnt  <= rd_cnt_nxt;
            stage_q <= stage_nxt;
        end
    end

    // NOTE: the frame buffer has no reset; every entry is rewritten before DRAIN can read it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign busy = (state == DRAIN) || (wr_cnt != '0);

endmodule

// File: tb/tb_fft_stage_unshuffle.sv
// Self-checking bench for fft_stage_unshuffle: table of frames, scoreboard queue, reset corner cases.
module tb_fft_stage_unshuffle;

    localparam int SAMPLES = 8;
    localparam int WIDTH   = 3;
    localparam int LOG2    = 3;

    logic             clk;
    logic             rst;
    logic [LOG2-1:0]  stage;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LOG2-1:0]  out_index;
    logic             out_last;
    logic             busy;

    fft_stage_unshuffle #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .stage     (stage),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LOG2-1:0]  index;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [2:0]  stage_a;  // stage driven on words 0..2
        logic [2:0]  stage_b;  // stage driven on words 3..7
        logic [23:0] din;
        logic [23:0] expd;
        logic        bp;       // input gaps + output backpressure
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [23:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
        logic [23:0] r;
        r = {a7[2:0], a6[2:0], a5[2:0], a4[2:0], a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
        return r;
    endfunction

    task automatic fill(input vec_t v);
        for (int k = 0; k < SAMPLES; k++) begin
            beat_t b;
            b.data  = v.expd[3*k +: 3];
            b.index = LOG2'(k);
            b.last  = (k == SAMPLES - 1);
            exp_q.push_back(b);
        end
        for (int k = 0; k < SAMPLES; k++) begin
            if (v.bp) begin
                int idle;
                idle = $urandom_range(0, 2);
                repeat (idle) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = v.din[3*k +: 3];
            stage    = (k < 3) ? v.stage_a : v.stage_b;
            check("fill_in_ready", in_ready, 1);
            check("fill_out_valid", out_valid, 0);
            check("fill_busy", busy, (k != 0) ? 1 : 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic bp, input int n);
        bit               pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int               got = 0;
        int               cyc = 0;
        bit               held = 0;
        logic [WIDTH-1:0] saved_d = '0;
        logic [LOG2-1:0]  saved_i = '0;
        while (got < n && cyc < 64) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            if (bp) begin
                in_valid = 1'b1;  // must be ignored while draining
                in_data  = WIDTH'($urandom);
            end
            check("drain_out_valid", out_valid, 1);
            check("drain_in_ready", in_ready, 0);
            check("drain_busy", busy, 1);
            if (held) begin
                check("hold_data", out_data, saved_d);
                check("hold_index", out_index, saved_i);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_index", out_index, e.index);
                    check("out_last", out_last, e.last);
                end
                got++;
                held = 0;
            end else begin
                held    = 1;
                saved_d = out_data;
                saved_i = out_index;
            end
            @(negedge clk);
            cyc++;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words expected %0d", got, n);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_index"}, out_index, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        stage     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0] = '{3'd2, 3'd2, pack8(0,1,2,3,4,5,6,7), pack8(0,2,4,6,1,3,5,7), 1'b0};
        vecs[1] = '{3'd1, 3'd1, pack8(0,1,2,3,4,5,6,7), pack8(0,2,1,3,4,6,5,7), 1'b0};
        vecs[2] = '{3'd0, 3'd0, pack8(0,1,2,3,4,5,6,7), pack8(0,1,2,3,4,5,6,7), 1'b0};
        vecs[3] = '{3'd3, 3'd3, pack8(0,1,2,3,4,5,6,7), pack8(0,2,4,6,1,3,5,7), 1'b0};
        vecs[4] = '{3'd2, 3'd0, pack8(0,1,2,3,4,5,6,7), pack8(0,2,4,6,1,3,5,7), 1'b0};
        vecs[5] = '{3'd2, 3'd2, pack8(7,6,5,4,3,2,1,0), pack8(7,5,3,1,6,4,2,0), 1'b1};
        vecs[6] = '{3'd1, 3'd1, pack8(7,6,5,4,3,2,1,0), pack8(7,5,6,4,3,1,2,0), 1'b0};

        @(negedge clk);
        @(negedge clk);
        idle_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fill(vecs[i]);
            drain(vecs[i].bp, SAMPLES);
            idle_checks("post_frame");
        end

        // Reset in the middle of a drain: outputs drop at once, remaining words are lost.
        fill(vecs[0]);
        drain(1'b0, 3);
        rst = 1'b1;
        #1;
        idle_checks("rst_drain");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a fill: the partial frame is discarded.
        stage    = 3'd2;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = WIDTH'(k + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("partial_busy", busy, 1);
        rst = 1'b1;
        #1;
        idle_checks("rst_fill");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill(vecs[6]);
        drain(1'b0, SAMPLES);
        idle_checks("post_reset_frame");
        check("scoreboard_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
